ex_operand_stage: RTL and testbench
===================================

// Module: ex_operand_stage
// PURPOSE
//  ID/EX pipeline stage that feeds the ALU. Takes decoded instruction fields from decode,
//  selects and forwards ALU operands, and registers input0/input1/aluselect for execute.
//  One-entry register with valid/ready handshake; supports flush, load-use interlock
//  and optional EX/MEM and MEM/WB bypass.
// PARAMETERS
//  DATA_WIDTH      32  operand / PC / immediate width
//  REG_ADDR_WIDTH  5   register index width
// PORTS
//  clk              in   1    clock, all state on rising edge
//  rst              in   1    synchronous, active-high reset
//  in_valid         in   1    decode presents an instruction
//  in_ready         out  1    stage accepts this cycle
//  in_rs1_addr      in   RAW  source 1 index     | in_rs2_addr in RAW  source 2 index
//  in_rs1_data      in   DW   regfile read 1     | in_rs2_data in DW   regfile read 2
//  in_pc            in   DW   instruction PC     | in_imm      in DW   sign-extended immediate
//  in_src1_pc       in   1    input0 = PC instead of rs1
//  in_src2_imm      in   1    input1 = imm instead of rs2
//  in_aluselect     in   4    ALU op code (0..13, passed through unchanged)
//  in_rd_addr       in   RAW  destination index  | in_reg_write in 1 writes rd
//  flush            in   1    kill held entry and any capture this cycle
//  exmem_reg_write  in   1    EX/MEM writes a register   | exmem_is_load in 1 it is a load
//  exmem_rd_addr    in   RAW  EX/MEM destination         | exmem_data    in DW its result
//  memwb_reg_write  in   1    MEM/WB writes a register   | memwb_rd_addr in RAW
//  memwb_data       in   DW   MEM/WB writeback value
//  out_valid        out  1    entry valid for execute    | out_ready in 1 execute accepts
//  out_input0       out  DW   ALU input0                 | out_input1 out DW ALU input1
//  out_aluselect    out  4    ALU op code                | out_rs2_data out DW store data
//  out_pc           out  DW   PC of entry                | out_rd_addr out RAW
//  out_reg_write    out  1    entry writes rd
// BEHAVIOUR
//  - Reset: out_valid=0; all other outputs 0. in_ready=1 the cycle after reset deasserts.
//  - Hazard h = in_valid & exmem_reg_write & exmem_is_load & exmem_rd_addr!=0 &
//    (exmem_rd_addr==in_rs1_addr & !in_src1_pc | exmem_rd_addr==in_rs2_addr & !in_src2_imm).
//  - in_ready = (!out_valid | out_ready) & !h & !flush (combinational).
//  - Capture when in_valid & in_ready: all out_* registered, out_valid=1; latency 1 cycle.
//  - out_valid & !out_ready & !flush: hold every output stable (no bypass re-evaluation).
//  - out_ready & !capture: out_valid<=0 next cycle.
//  - flush: out_valid<=0 next cycle regardless of in_valid/out_ready; overrides capture.
//  - Operand resolve (at capture only), per source, first match wins:
//    1) addr==0 -> 0; 2) EX/MEM match, reg_write, not load -> exmem_data;
//    3) MEM/WB match, reg_write -> memwb_data; 4) regfile data.
//    input0 = in_src1_pc ? in_pc : rs1'. input1 = in_src2_imm ? in_imm : rs2'.
//    out_rs2_data = rs2' always (store data), even when in_src2_imm=1.
//  - Both sources matching the same rd each receive the forwarded value.
//  - Decode must hold in_* stable while in_valid & !in_ready.
// CONFIGURATION
//  EX_OPERAND_FWD_EN defined: bypass rules 2) and 3) active; only load-use stalls.
//  Not defined: no bypass; h additionally true for any used source (addr!=0) matching an
//   EX/MEM or MEM/WB destination with reg_write=1; operands always regfile/PC/imm.
// TESTING
//  1 rst=1 2 cycles -> out_valid=0, all outputs 0; then in_ready=1 with out_ready=1.
//  2 rs1=x5 data 7, imm 0xFFFFFFFC, src2_imm=1, op 0 -> next cycle input0=7,
//    input1=0xFFFFFFFC, aluselect=0, out_valid=1.
//  3 FWD_EN: rs1=x3, exmem rd=x3 data 0x11, memwb rd=x3 data 0x22 -> input0=0x11;
//    rs2=x0 with exmem rd=x0 data 0x55 -> input1=0.
//  4 exmem_is_load, rd=x4, in rs2=x4 src2_imm=0 -> in_ready=0 until load leaves EX/MEM;
//    with src2_imm=1 and rs1!=x4 -> accepted.
//  5 out_valid=1, out_ready=0 for 3 cycles, new in_valid -> outputs unchanged, in_ready=0;
//    flush in cycle 2 -> out_valid=0 next cycle, new instruction not captured that cycle.
//  6 FWD_EN undefined: memwb rd=x6 reg_write=1, rs1=x6 -> in_ready=0; memwb clears -> accepted.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: one-entry register feeding the ALU with load-use interlock.
// Define EX_OPERAND_FWD_EN to enable EX/MEM and MEM/WB operand bypass.
module ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
    input  logic [DATA_WIDTH-1:0]     in_rs1_data,
    input  logic [DATA_WIDTH-1:0]     in_rs2_data,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic                      in_src1_pc,
    input  logic                      in_src2_imm,
    input  logic [3:0]                in_aluselect,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
    input  logic                      in_reg_write,

    input  logic                      flush,

    input  logic                      exmem_reg_write,
    input  logic                      exmem_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     exmem_data,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0]     memwb_data,

    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_input0,
    output logic [DATA_WIDTH-1:0]     out_input1,
    output logic [3:0]                out_aluselect,
    output logic [DATA_WIDTH-1:0]     out_rs2_data,
    output logic [DATA_WIDTH-1:0]     out_pc,
    output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
    output logic                      out_reg_write
);

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

    logic                  rs1_used;
    logic                  rs2_used;
    logic                  rs1_hit_ex;
    logic                  rs2_hit_ex;
    logic                  rs1_hit_wb;
    logic                  rs2_hit_wb;
    logic                  load_use;
    logic                  hazard;
    logic                  capture;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic [DATA_WIDTH-1:0] input0_nxt;
    logic [DATA_WIDTH-1:0] input1_nxt;

    // A source selected away to PC/imm never needs a register value for the ALU.
    assign rs1_used   = !in_src1_pc  && (in_rs1_addr != ZERO_REG);
    assign rs2_used   = !in_src2_imm && (in_rs2_addr != ZERO_REG);
    assign rs1_hit_ex = (exmem_rd_addr == in_rs1_addr);
    assign rs2_hit_ex = (exmem_rd_addr == in_rs2_addr);
    assign rs1_hit_wb = (memwb_rd_addr == in_rs1_addr);
    assign rs2_hit_wb = (memwb_rd_addr == in_rs2_addr);

    assign load_use = in_valid && exmem_reg_write && exmem_is_load &&
                      (exmem_rd_addr != ZERO_REG) &&
                      ((rs1_hit_ex && !in_src1_pc) || (rs2_hit_ex && !in_src2_imm));

`ifdef EX_OPERAND_FWD_EN
    assign hazard = load_use;
`else
    // Without bypass any in-flight producer of a used source must retire first.
    assign hazard = load_use ||
                    (in_valid && exmem_reg_write &&
                     ((rs1_used && rs1_hit_ex) || (rs2_used && rs2_hit_ex))) ||
                    (in_valid && memwb_reg_write &&
                     ((rs1_used && rs1_hit_wb) || (rs2_used && rs2_hit_wb)));

    logic unused_fwd_data;
    assign unused_fwd_data = ^{exmem_data, memwb_data};
`endif

    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign capture  = in_valid && in_ready;

    always_comb begin
        rs1_val = in_rs1_data;
        if (in_rs1_addr == ZERO_REG) begin
            rs1_val = '0;
        end
`ifdef EX_OPERAND_FWD_EN
        else if (exmem_reg_write && !exmem_is_load && rs1_hit_ex) begin
            rs1_val = exmem_data;
        end else if (memwb_reg_write && rs1_hit_wb) begin
            rs1_val = memwb_data;
        end
`endif
    end

    always_comb begin
        rs2_val = in_rs2_data;
        if (in_rs2_addr == ZERO_REG) begin
            rs2_val = '0;
        end
`ifdef EX_OPERAND_FWD_EN
        else if (exmem_reg_write && !exmem_is_load && rs2_hit_ex) begin
            rs2_val = exmem_data;
        end else if (memwb_reg_write && rs2_hit_wb) begin
            rs2_val = memwb_data;
        end
`endif
    end

    assign input0_nxt = in_src1_pc  ? in_pc  : rs1_val;
    assign input1_nxt = in_src2_imm ? in_imm : rs2_val;

    // Held entries are never re-resolved; the bypass sources may move on underneath.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_input0    <= '0;
            out_input1    <= '0;
            out_aluselect <= '0;
            out_rs2_data  <= '0;
            out_pc        <= '0;
            out_rd_addr   <= '0;
            out_reg_write <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid     <= 1'b1;
            out_input0    <= input0_nxt;
            out_input1    <= input1_nxt;
            out_aluselect <= in_aluselect;
            out_rs2_data  <= rs2_val;
            out_pc        <= in_pc;
            out_rd_addr   <= in_rd_addr;
            out_reg_write <= in_reg_write;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage; expectations follow EX_OPERAND_FWD_EN if defined.
module tb_ex_operand_stage;

`ifdef EX_OPERAND_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
    logic        in_src1_pc, in_src2_imm, in_reg_write;
    logic [3:0]  in_aluselect;
    logic        flush;
    logic        exmem_reg_write, exmem_is_load;
    logic [4:0]  exmem_rd_addr;
    logic [31:0] exmem_data;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd_addr;
    logic [31:0] memwb_data;
    logic        out_valid, out_ready;
    logic [31:0] out_input0, out_input1, out_rs2_data, out_pc;
    logic [3:0]  out_aluselect;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_src1_pc(in_src1_pc), .in_src2_imm(in_src2_imm),
        .in_aluselect(in_aluselect), .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
        .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_is_load(exmem_is_load),
        .exmem_rd_addr(exmem_rd_addr), .exmem_data(exmem_data),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_data(memwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_input0(out_input0), .out_input1(out_input1),
        .out_aluselect(out_aluselect), .out_rs2_data(out_rs2_data),
        .out_pc(out_pc), .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
    );

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] rs1_d, rs2_d, pc, imm;
        logic        s1pc, s2imm;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic        ex_rw, ex_ld;
        logic [4:0]  ex_rd;
        logic [31:0] ex_d;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_d;
        logic        exp_ready;
        logic [31:0] exp_in0, exp_in1, exp_rs2;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_pipe();
        exmem_reg_write = 0; exmem_is_load = 0; exmem_rd_addr = 0; exmem_data = 0;
        memwb_reg_write = 0; memwb_rd_addr = 0; memwb_data = 0;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1;
        in_rs1_addr = v.rs1; in_rs2_addr = v.rs2; in_rs1_data = v.rs1_d; in_rs2_data = v.rs2_d;
        in_pc = v.pc; in_imm = v.imm; in_src1_pc = v.s1pc; in_src2_imm = v.s2imm;
        in_aluselect = v.op; in_rd_addr = v.rd; in_reg_write = v.rw;
        exmem_reg_write = v.ex_rw; exmem_is_load = v.ex_ld; exmem_rd_addr = v.ex_rd; exmem_data = v.ex_d;
        memwb_reg_write = v.wb_rw; memwb_rd_addr = v.wb_rd; memwb_data = v.wb_d;
    endtask

    // Simple instruction: rs1/rs2 from regfile, no producers in flight.
    task automatic drive_simple(input logic [31:0] d1, input logic [31:0] d2,
                                input logic [3:0] op, input logic [31:0] pc);
        vec_t v;
        v = '{1, 2, d1, d2, pc, 0, 0, 0, op, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, d1, d2, d2};
        drive(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rs1 rs2 rs1_d  rs2_d  pc      imm           s1 s2 op rd rw  exrw ld exrd exd    wbrw wbrd wbd    rdy  in0           in1           rs2
        vecs[0]  = '{5,  0,  32'h7,  32'h99, 32'h1000, 32'hFFFFFFFC, 0, 1, 0, 10, 1, 0, 0, 0, 32'h0,  0, 0, 32'h0,  1,   32'h7,        32'hFFFFFFFC, 32'h0};
        vecs[1]  = '{1,  2,  32'h33, 32'h44, 32'h100,  32'h8,        1, 0, 13, 11, 1, 0, 0, 0, 32'h0, 0, 0, 32'h0,  1,   32'h100,      32'h44,       32'h44};
        vecs[2]  = '{3,  2,  32'h30, 32'h20, 32'h200,  32'h0,        0, 0, 2, 12, 1, 1, 0, 3, 32'h11, 1, 3, 32'h22, FWD, 32'h11,       32'h20,       32'h20};
        vecs[3]  = '{7,  0,  32'h70, 32'h66, 32'h204,  32'h0,        0, 0, 3, 13, 1, 1, 0, 0, 32'h55, 0, 0, 32'h0,  1,   32'h70,       32'h0,        32'h0};
        vecs[4]  = '{6,  1,  32'h60, 32'h10, 32'h208,  32'h0,        0, 0, 4, 14, 0, 0, 0, 0, 32'h0,  1, 6, 32'h77, FWD, 32'h77,       32'h10,       32'h10};
        vecs[5]  = '{1,  4,  32'h1,  32'h40, 32'h20C,  32'h0,        0, 0, 5, 15, 1, 1, 1, 4, 32'h123,0, 0, 32'h0,  0,   32'h0,        32'h0,        32'h0};
        vecs[6]  = '{1,  4,  32'hA,  32'h40, 32'h210,  32'h5,        0, 1, 6, 16, 1, 1, 1, 4, 32'h123,0, 0, 32'h0,  1,   32'hA,        32'h5,        32'h40};
        vecs[7]  = '{9,  9,  32'h90, 32'h91, 32'h214,  32'h0,        0, 0, 7, 17, 1, 0, 0, 0, 32'h0,  1, 9, 32'hAB, FWD, 32'hAB,       32'hAB,       32'hAB};
        vecs[8]  = '{0,  0,  32'h5,  32'h6,  32'h218,  32'h0,        0, 0, 8, 18, 1, 1, 1, 0, 32'h9,  0, 0, 32'h0,  1,   32'h0,        32'h0,        32'h0};
        vecs[9]  = '{4,  2,  32'h44, 32'h20, 32'h300,  32'h0,        1, 0, 9, 19, 1, 1, 1, 4, 32'h9,  0, 0, 32'h0,  1,   32'h300,      32'h20,       32'h20};
        vecs[10] = '{8,  9,  32'h80, 32'h90, 32'h304,  32'h0,        0, 0, 12, 20, 1, 1, 0, 8, 32'h88, 1, 9, 32'h99, FWD, 32'h88,      32'h99,       32'h99};

        rst = 1; flush = 0; out_ready = 1;
        vecs[0].exp_ready = 1;
        drive(vecs[0]);
        in_valid = 0;
        clear_pipe();

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", {31'b0, out_valid}, 0);
        chk("rst out_input0", out_input0, 0);
        chk("rst out_input1", out_input1, 0);
        chk("rst out_aluselect", {28'b0, out_aluselect}, 0);
        chk("rst out_rs2_data", out_rs2_data, 0);
        chk("rst out_pc", out_pc, 0);
        chk("rst out_rd/reg_write", {26'b0, out_rd_addr, out_reg_write}, 0);
        @(negedge clk);
        rst = 0;
        #1 chk("post-rst in_ready", {31'b0, in_ready}, 1);

        // Table vectors, one per cycle with execute always accepting
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1 chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_ready});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_ready});
            if (vecs[i].exp_ready) begin
                chk($sformatf("v%0d input0", i), out_input0, vecs[i].exp_in0);
                chk($sformatf("v%0d input1", i), out_input1, vecs[i].exp_in1);
                chk($sformatf("v%0d rs2_data", i), out_rs2_data, vecs[i].exp_rs2);
                chk($sformatf("v%0d aluselect", i), {28'b0, out_aluselect}, {28'b0, vecs[i].op});
                chk($sformatf("v%0d pc", i), out_pc, vecs[i].pc);
                chk($sformatf("v%0d rd/rw", i), {26'b0, out_rd_addr, out_reg_write},
                    {26'b0, vecs[i].rd, vecs[i].rw});
            end
        end
        @(negedge clk);
        in_valid = 0;
        clear_pipe();
        @(posedge clk);
        #1 chk("drain out_valid", {31'b0, out_valid}, 0);

        // Load-use stall until the load leaves EX/MEM
        @(negedge clk);
        drive_simple(32'h1, 32'h42, 4'd5, 32'h600);
        in_rs2_addr = 4;
        exmem_reg_write = 1; exmem_is_load = 1; exmem_rd_addr = 4; exmem_data = 32'hDEAD;
        for (int c = 0; c < 2; c++) begin
            #1 chk("load stall in_ready", {31'b0, in_ready}, 0);
            @(posedge clk);
            #1 chk("load stall out_valid", {31'b0, out_valid}, 0);
            @(negedge clk);
        end
        clear_pipe();
        #1 chk("load clear in_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        chk("load clear out_valid", {31'b0, out_valid}, 1);
        chk("load clear input1", out_input1, 32'h42);

        // Hold under backpressure, then flush while a new instruction waits
        @(negedge clk);
        drive_simple(32'hA1, 32'hA2, 4'd6, 32'h400);
        @(posedge clk);
        @(negedge clk);
        out_ready = 0;
        drive_simple(32'hB1, 32'hB2, 4'd7, 32'h500);
        for (int c = 0; c < 2; c++) begin
            #1 chk("hold in_ready", {31'b0, in_ready}, 0);
            @(posedge clk);
            #1;
            chk("hold out_valid", {31'b0, out_valid}, 1);
            chk("hold input0", out_input0, 32'hA1);
            chk("hold input1", out_input1, 32'hA2);
            chk("hold aluselect", {28'b0, out_aluselect}, 32'd6);
            chk("hold pc", out_pc, 32'h400);
            @(negedge clk);
        end
        flush = 1;
        #1 chk("flush in_ready", {31'b0, in_ready}, 0);
        @(posedge clk);
        #1 chk("flush out_valid", {31'b0, out_valid}, 0);
        @(negedge clk);
        flush = 0; out_ready = 1;
        #1 chk("post-flush in_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        chk("post-flush out_valid", {31'b0, out_valid}, 1);
        chk("post-flush input0", out_input0, 32'hB1);
        chk("post-flush pc", out_pc, 32'h500);
        @(negedge clk);
        in_valid = 0;

`ifndef EX_OPERAND_FWD_EN
        // No bypass: MEM/WB producer of rs1 stalls until it retires
        @(negedge clk);
        drive_simple(32'h61, 32'h62, 4'd8, 32'h700);
        in_rs1_addr = 6;
        memwb_reg_write = 1; memwb_rd_addr = 6; memwb_data = 32'hBEEF;
        for (int c = 0; c < 2; c++) begin
            #1 chk("wb stall in_ready", {31'b0, in_ready}, 0);
            @(posedge clk);
            @(negedge clk);
        end
        clear_pipe();
        #1 chk("wb clear in_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        chk("wb clear out_valid", {31'b0, out_valid}, 1);
        chk("wb clear input0", out_input0, 32'h61);
        @(negedge clk);
        in_valid = 0;
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
